// File: rtl/sum_sched.sv
// Round-robin share of one partial-sum accumulator among NUM_REQ requesters; build option SUM_SAT_EN selects saturating adds.
// Latency: result is registered on the edge that accepts the last partial sum, out_valid visible the next cycle.
// Backpressure: only completing requests stall on a full output; non-completing requests keep flowing.
module sum_sched #(
    parameter int NUM_REQ      = 3,
    parameter int DATA_W       = 8,
    parameter int IDX_W        = 2,
    parameter int ACC_W        = 10,
    parameter int PSUM_PER_OUT = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*IDX_W-1:0]   req_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       busy
);

    localparam int NIDX  = 1 << IDX_W;
    localparam int CNT_W = (PSUM_PER_OUT > 1) ? $clog2(PSUM_PER_OUT) : 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PSUM_PER_OUT - 1);

    logic [ACC_W-1:0]  acc [NIDX];
    logic [CNT_W-1:0]  cnt [NIDX];
    logic [PTR_W-1:0]  ptr;

    logic [DATA_W-1:0] data_a [NUM_REQ];
    logic [IDX_W-1:0]  idx_a  [NUM_REQ];
    logic [NUM_REQ-1:0] completing;
    logic [NUM_REQ-1:0] eligible;
    logic              slot_free;
    logic              found;
    logic [PTR_W-1:0]  gnt;
    logic [PTR_W-1:0]  cand;
    logic              fire;
    logic              sel_done;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_data;
    logic [ACC_W-1:0]  sum;

    // Unpack requests; a completing request may only go when the output slot frees this cycle
    always_comb begin
        slot_free = !out_valid || out_ready;
        for (int r = 0; r < NUM_REQ; r++) begin
            data_a[r]     = req_data[r*DATA_W +: DATA_W];
            idx_a[r]      = req_idx[r*IDX_W +: IDX_W];
            completing[r] = (cnt[idx_a[r]] == LAST_CNT);
            eligible[r]   = req_valid[r] && (!completing[r] || slot_free);
        end
    end

    // Round-robin search starting just after the last-accepted requester
    always_comb begin
        found     = 1'b0;
        gnt       = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
        if (found && rst_n) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // Selected request and its running sum (wrapping, or clamped so an overflowed output stays at max)
`ifdef SUM_SAT_EN
    logic [ACC_W:0] sum_wide;
    always_comb begin
        fire     = |req_ready;
        sel_idx  = idx_a[gnt];
        sel_data = data_a[gnt];
        sel_done = completing[gnt];
        sum_wide = {1'b0, acc[sel_idx]} + (ACC_W+1)'(sel_data);
        sum      = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    end
`else
    always_comb begin
        fire     = |req_ready;
        sel_idx  = idx_a[gnt];
        sel_data = data_a[gnt];
        sel_done = completing[gnt];
        sum      = acc[sel_idx] + ACC_W'(sel_data);
    end
`endif

    // Per-index accumulators and counters; a completing accept restarts its index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NIDX; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (fire) begin
            if (sel_done) begin
                acc[sel_idx] <= '0;
                cnt[sel_idx] <= '0;
            end else begin
                acc[sel_idx] <= sum;
                cnt[sel_idx] <= cnt[sel_idx] + CNT_W'(1);
            end
        end
    end

    // Pointer remembers the last accepted requester; reset gives requester 0 top priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= PTR_W'(NUM_REQ - 1);
        end else if (fire) begin
            ptr <= gnt;
        end
    end

    // Output register: pop clears, a completing accept loads (wins over a same-cycle pop)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (fire && sel_done) begin
                out_valid <= 1'b1;
                out_data  <= sum;
                out_idx   <= sel_idx;
            end
        end
    end

    // Busy while any index holds partial sums or a result is waiting
    always_comb begin
        busy = out_valid;
        for (int i = 0; i < NIDX; i++) begin
            if (cnt[i] != '0) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_sched.sv
module tb_sum_sched;

    localparam int PSUM = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [23:0] req_data;
    logic [5:0]  req_idx;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic [1:0]  out_idx;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    sum_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_idx   (req_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int expect_total(input int tot);
`ifdef SUM_SAT_EN
        return (tot > 1023) ? 1023 : tot;
`else
        return tot % 1024;
`endif
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_idx   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_req(input int r, input logic v, input int d, input int ix);
        req_valid[r]         = v;
        req_data[r*8 +: 8]   = 8'(d);
        req_idx[r*2 +: 2]    = 2'(ix);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 3'b111; req_data = '0; req_idx = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_data !== 10'd0 || out_idx !== 2'd0) begin n_err++; $display("FAIL reset_out_regs: got %0d/%0d expected 0/0", out_data, out_idx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL reset_priority: got %b expected 001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        int vals[5] = '{10, 20, 30, 40, 50};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1'b1, vals[i], 1);
            @(negedge clk);
            n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL single_ready%0d: got %b expected 001", i, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_vec++; if (out_data !== 10'd150) begin n_err++; $display("FAIL single_data: got %0d expected 150", out_data); end
        n_vec++; if (out_idx !== 2'd1) begin n_err++; $display("FAIL single_idx: got %0d expected 1", out_idx); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_hi: got %b expected 1", busy); end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop: got %b expected 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_lo: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int d[3];
        int order[5] = '{0, 1, 2, 0, 1};
        int total = 0;
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            d[r] = $urandom_range(0, 200);
            set_req(r, 1'b1, d[r], 0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total += d[order[i]];
            n_vec++; if (req_ready !== 3'(1 << order[i])) begin n_err++; $display("FAIL rr_order%0d: got %b expected %b", i, req_ready, 3'(1 << order[i])); end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_idx !== 2'd0) begin n_err++; $display("FAIL rr_result: got valid %b idx %0d expected 1/0", out_valid, out_idx); end
        n_vec++; if (out_data !== 10'(total)) begin n_err++; $display("FAIL rr_data: got %0d expected %0d", out_data, total); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(2, 1'b1, 3, 2);
        repeat (4) @(posedge clk);
        #1 req_valid = '0;
        set_req(0, 1'b1, 1, 0);
        repeat (5) @(posedge clk);
        #1 req_valid = '0;
        set_req(1, 1'b1, 7, 3);
        set_req(2, 1'b1, 4, 2);
        out_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL bp_block_a: got %b expected 010", req_ready); end
        n_vec++; if (out_valid !== 1'b1 || out_data !== 10'd5) begin n_err++; $display("FAIL bp_hold_a: got %b/%0d expected 1/5", out_valid, out_data); end
        @(negedge clk);
        n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL bp_block_b: got %b expected 010", req_ready); end
        n_vec++; if (out_data !== 10'd5 || out_idx !== 2'd0) begin n_err++; $display("FAIL bp_hold_b: got %0d/%0d expected 5/0", out_data, out_idx); end
        out_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL bp_release: got %b expected 100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0; out_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_b2b_valid: got %b expected 1", out_valid); end
        n_vec++; if (out_data !== 10'd16 || out_idx !== 2'd2) begin n_err++; $display("FAIL bp_b2b_data: got %0d/%0d expected 16/2", out_data, out_idx); end
    endtask

    task automatic test_saturation();
        int exp_v;
`ifdef SUM_SAT_EN
        exp_v = 1023;
`else
        exp_v = 251;
`endif
        do_reset();
        set_req(0, 1'b1, 255, 0);
        repeat (5) @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 10'(exp_v)) begin n_err++; $display("FAIL sat_data: got %b/%0d expected 1/%0d", out_valid, out_data, exp_v); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        set_req(0, 1'b1, $urandom_range(1, 255), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        set_req(0, 1'b1, 1, 0);
        @(negedge clk);
        n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL mid_rst_ready: got %b expected 000", req_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_early%0d: got %b expected 0", i, out_valid); end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 10'd5 || out_idx !== 2'd0) begin n_err++; $display("FAIL mid_result: got %b/%0d/%0d expected 1/5/0", out_valid, out_data, out_idx); end
    endtask

    task automatic test_random();
        int m_cnt[4];
        int m_tot[4];
        int m_ptr, m_od, m_oi, exp_g, r, ix;
        bit m_ov, slot, exp_busy;
        logic [2:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_tot[i] = 0; end
        m_ptr = 2; m_ov = 1'b0; m_od = 0; m_oi = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = 3'($urandom_range(0, 7));
            req_data  = 24'($urandom());
            req_idx   = 6'($urandom());
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            slot  = !m_ov || out_ready;
            exp_g = -1;
            for (int k = 1; k <= 3; k++) begin
                r  = (m_ptr + k) % 3;
                ix = int'(req_idx[r*2 +: 2]);
                if (exp_g < 0 && req_valid[r] && (m_cnt[ix] != PSUM - 1 || slot)) exp_g = r;
            end
            exp_rdy  = (exp_g >= 0) ? 3'(1 << exp_g) : 3'b000;
            exp_busy = m_ov;
            for (int i = 0; i < 4; i++) if (m_cnt[i] != 0) exp_busy = 1'b1;
            n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
            n_vec++; if (out_valid !== m_ov) begin n_err++; $display("FAIL rand_valid c%0d: got %b expected %b", cyc, out_valid, m_ov); end
            if (m_ov) begin
                n_vec++; if (out_data !== 10'(m_od) || out_idx !== 2'(m_oi)) begin n_err++; $display("FAIL rand_out c%0d: got %0d/%0d expected %0d/%0d", cyc, out_data, out_idx, m_od, m_oi); end
            end
            n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL rand_busy c%0d: got %b expected %b", cyc, busy, exp_busy); end
            if (m_ov && out_ready) m_ov = 1'b0;
            if (exp_g >= 0) begin
                ix = int'(req_idx[exp_g*2 +: 2]);
                m_ptr = exp_g;
                m_tot[ix] += int'(req_data[exp_g*8 +: 8]);
                m_cnt[ix]++;
                if (m_cnt[ix] == PSUM) begin
                    m_ov = 1'b1; m_od = expect_total(m_tot[ix]); m_oi = ix;
                    m_tot[ix] = 0; m_cnt[ix] = 0;
                end
            end
            @(posedge clk); #1;
        end
        req_valid = '0; out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_idx = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
